// File: rtl/iob_pcie_chnl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iob_pcie_chnl_pkg
// Brief    : Shared state encodings, mode codes and STATUS layout for the
//            PCIe channel loopback core.
// Revision : 1.0
// ============================================================================
package iob_pcie_chnl_pkg;

    localparam int c_ST_W = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE   = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_RX     = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_TXPREP = 2'd2;
    localparam logic [c_ST_W-1:0] c_ST_TX     = 2'd3;

    localparam logic [1:0] c_MODE_ECHO = 2'd0;
    localparam logic [1:0] c_MODE_PAT  = 2'd1;
    localparam logic [1:0] c_MODE_SINK = 2'd2;

    localparam int c_STAT_BUSY  = 31;
    localparam int c_STAT_OVF   = 30;
    localparam int c_STAT_ABORT = 29;

    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? c_CNT_MAX : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_pcie_sfifo.sv
`default_nettype none
// ============================================================================
// Module   : iob_pcie_sfifo
// Brief    : Synchronous first-word-fall-through FIFO with a registered head.
// Revision : 1.0
// ============================================================================
module iob_pcie_sfifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int          c_DEPTH = 2**AW;
    localparam logic [AW:0] c_FULL  = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_head;

    logic             w_wr;
    logic             w_rd;
    logic [AW-1:0]    w_rptr_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    assign full    = (r_level == c_FULL);
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_head;

    assign w_wr       = wr_en & ~full & ~flush;
    assign w_rd       = rd_en & ~empty & ~flush;
    assign w_rptr_nxt = r_rptr + AW'(w_rd);

    // The head preloads the next entry; a write landing in that slot bypasses the array.
    assign w_head_nxt = (w_wr && (r_wptr == w_rptr_nxt)) ? wr_data : r_mem[w_rptr_nxt];

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_head  <= '0;
        end else begin
            r_head <= w_head_nxt;
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                r_rptr <= w_rptr_nxt;
                if (w_wr) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                case ({w_wr, w_rd})
                    2'b10:   r_level <= r_level + 1'b1;
                    2'b01:   r_level <= r_level - 1'b1;
                    default: r_level <= r_level;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iob_pcie_chnl_loopback.sv
`default_nettype none
// ============================================================================
// Module   : iob_pcie_chnl_loopback
// Brief    : RIFFA channel loopback returning received data as echo, a
//            counting pattern, or nothing (sink).
// Revision : 1.0
// ============================================================================
module iob_pcie_chnl_loopback
    import iob_pcie_chnl_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int C_FIFO_AW        = 6
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [1:0]                  MODE,
    output logic [31:0]                 STATUS,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN,
    output logic                        CHNL_TX_CLK,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [31:0]                 CHNL_TX_LEN,
    output logic [30:0]                 CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN
);

    // Data width must be 32, 64 or 128.
    localparam int          c_WPB      = C_PCI_DATA_WIDTH / 32;
    localparam int          c_WPB_LOG2 = $clog2(c_WPB);
    localparam logic [31:0] c_WPB_W    = 32'(c_WPB);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic [31:0]       r_len;
    logic [31:0]       r_rcount;
    logic [31:0]       r_tcount;
    logic [31:0]       r_tx_len;
    logic [1:0]        r_mode;
    logic              r_ovf;
    logic              r_abort;

    logic              w_is_echo;
    logic              w_is_pat;
    logic              w_busy;
    logic              w_rx_beat;
    logic              w_rx_done;
    logic              w_rx_abort;
    logic              w_tx_valid;
    logic              w_tx_xfer;
    logic              w_tx_done;
    logic [31:0]       w_rcount_nxt;
    logic [31:0]       w_tcount_inc;
    logic [31:0]       w_fifo_words;
    logic [31:0]       w_tx_len_calc;

    logic                        w_fifo_flush;
    logic                        w_fifo_wr;
    logic                        w_fifo_rd;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [C_FIFO_AW:0]          w_fifo_level;
    logic [C_PCI_DATA_WIDTH-1:0] w_fifo_dout;
    logic [C_PCI_DATA_WIDTH-1:0] w_pat_data;
    logic                        w_unused;

    assign w_unused = &{1'b0, CHNL_RX_LAST, CHNL_RX_OFF, CHNL_TX_ACK};

    assign w_is_echo = (r_mode == c_MODE_ECHO);
    assign w_is_pat  = (r_mode == c_MODE_PAT);
    assign w_busy    = (r_state != c_ST_IDLE);

    assign w_rx_beat    = (r_state == c_ST_RX) & CHNL_RX_DATA_VALID;
    assign w_rcount_nxt = w_rx_beat ? sat_add(r_rcount, c_WPB_W) : r_rcount;
    assign w_rx_done    = (w_rcount_nxt >= r_len);
    assign w_rx_abort   = (r_state == c_ST_RX) & ~w_rx_done & ~CHNL_RX;

    assign w_fifo_words = 32'(w_fifo_level) << c_WPB_LOG2;

    always_comb begin
        w_tx_len_calc = '0;
        if (w_is_echo) begin
            w_tx_len_calc = (r_rcount < w_fifo_words) ? r_rcount : w_fifo_words;
        end else if (w_is_pat) begin
            w_tx_len_calc = r_len;
        end
    end

    assign w_tx_valid   = (r_state == c_ST_TX) & (w_is_pat | (w_is_echo & ~w_fifo_empty));
    assign w_tx_xfer    = w_tx_valid & CHNL_TX_DATA_REN;
    assign w_tcount_inc = sat_add(r_tcount, c_WPB_W);
    assign w_tx_done    = (w_tcount_inc >= r_tx_len);

    assign w_fifo_flush = (r_state == c_ST_IDLE) & CHNL_RX;
    assign w_fifo_wr    = w_rx_beat & w_is_echo & ~w_fifo_full;
    assign w_fifo_rd    = w_tx_xfer & w_is_echo;

    iob_pcie_sfifo #(
        .WIDTH (C_PCI_DATA_WIDTH),
        .AW    (C_FIFO_AW)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .flush   (w_fifo_flush),
        .wr_en   (w_fifo_wr),
        .wr_data (CHNL_RX_DATA),
        .rd_en   (w_fifo_rd),
        .rd_data (w_fifo_dout),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .level   (w_fifo_level)
    );

    // Lane i carries the 1-based index of that word within the transfer.
    generate
        for (genvar gi = 0; gi < c_WPB; gi++) begin : g_lane
            assign w_pat_data[gi*32 +: 32] = r_tcount + 32'(gi) + 32'd1;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (CHNL_RX) begin
                    w_state_nxt = c_ST_RX;
                end
            end
            c_ST_RX: begin
                if (w_rx_done || !CHNL_RX) begin
                    w_state_nxt = c_ST_TXPREP;
                end
            end
            c_ST_TXPREP: begin
                w_state_nxt = (w_tx_len_calc == '0) ? c_ST_IDLE : c_ST_TX;
            end
            c_ST_TX: begin
                if (w_tx_xfer && w_tx_done) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_len    <= '0;
            r_mode   <= c_MODE_ECHO;
            r_rcount <= '0;
            r_tcount <= '0;
            r_tx_len <= '0;
            r_ovf    <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (CHNL_RX) begin
                        r_len    <= CHNL_RX_LEN;
                        r_mode   <= MODE;
                        r_rcount <= '0;
                        r_ovf    <= 1'b0;
                        r_abort  <= 1'b0;
                    end
                end
                c_ST_RX: begin
                    r_rcount <= w_rcount_nxt;
                    if (w_rx_beat && w_is_echo && w_fifo_full) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_rx_abort) begin
                        r_abort <= 1'b1;
                    end
                end
                c_ST_TXPREP: begin
                    r_tx_len <= w_tx_len_calc;
                    r_tcount <= '0;
                end
                c_ST_TX: begin
                    if (w_tx_xfer) begin
                        r_tcount <= w_tcount_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign CHNL_RX_CLK        = CLK;
    assign CHNL_TX_CLK        = CLK;
    assign CHNL_RX_ACK        = (r_state == c_ST_RX);
    assign CHNL_RX_DATA_REN   = (r_state == c_ST_RX);
    assign CHNL_TX            = (r_state == c_ST_TX);
    assign CHNL_TX_LAST       = 1'b1;
    assign CHNL_TX_OFF        = '0;
    assign CHNL_TX_LEN        = r_tx_len;
    assign CHNL_TX_DATA_VALID = w_tx_valid;
    assign CHNL_TX_DATA       = (r_state != c_ST_TX) ? '0 :
                                (w_is_echo ? w_fifo_dout : w_pat_data);

    always_comb begin
        STATUS               = {8'd0, r_rcount[23:0]};
        STATUS[c_STAT_BUSY]  = w_busy;
        STATUS[c_STAT_OVF]   = r_ovf;
        STATUS[c_STAT_ABORT] = r_abort;
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_pcie_chnl_loopback.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_iob_pcie_chnl_loopback
// Brief    : Three loopback instances (64/64-deep, 32/4-deep, 128/64-deep)
//            sharing one stimulus bus; sel picks the instance under test.
// Revision : 1.0
// ============================================================================
module tb_iob_pcie_chnl_loopback;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   sel = 2'd0;
    logic [1:0]   mode = 2'd0;
    logic         rx_req = 1'b0;
    logic [31:0]  rx_len = '0;
    logic [127:0] rx_data = '0;
    logic         rx_valid = 1'b0;
    logic         tx_ren = 1'b0;

    logic [2:0]   d_unused_rxclk, d_unused_txclk, d_ack, d_ren, d_tx, d_last, d_valid;
    logic [31:0]  d_status [3];
    logic [31:0]  d_tx_len [3];
    logic [30:0]  d_off [3];
    logic [63:0]  data0;
    logic [31:0]  data1;
    logic [127:0] data2;

    logic         ack, ren, tx, tx_valid, tx_last;
    logic [31:0]  status, tx_len;
    logic [30:0]  tx_off;
    logic [127:0] tx_data;

    int           checks = 0;
    int           errors = 0;
    int           tx_cycles = 0;
    logic [31:0]  exp_q [$];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (|d_tx) tx_cycles <= tx_cycles + 1;
    end

    iob_pcie_chnl_loopback #(.C_PCI_DATA_WIDTH(64), .C_FIFO_AW(6)) u_dut0 (
        .CLK(clk), .RST(rst), .MODE(mode), .STATUS(d_status[0]),
        .CHNL_RX_CLK(d_unused_rxclk[0]), .CHNL_RX(rx_req && sel == 2'd0), .CHNL_RX_ACK(d_ack[0]),
        .CHNL_RX_LAST(1'b1), .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(31'd0),
        .CHNL_RX_DATA(rx_data[63:0]), .CHNL_RX_DATA_VALID(rx_valid), .CHNL_RX_DATA_REN(d_ren[0]),
        .CHNL_TX_CLK(d_unused_txclk[0]), .CHNL_TX(d_tx[0]), .CHNL_TX_ACK(d_tx[0]),
        .CHNL_TX_LAST(d_last[0]), .CHNL_TX_LEN(d_tx_len[0]), .CHNL_TX_OFF(d_off[0]),
        .CHNL_TX_DATA(data0), .CHNL_TX_DATA_VALID(d_valid[0]), .CHNL_TX_DATA_REN(tx_ren));

    iob_pcie_chnl_loopback #(.C_PCI_DATA_WIDTH(32), .C_FIFO_AW(2)) u_dut1 (
        .CLK(clk), .RST(rst), .MODE(mode), .STATUS(d_status[1]),
        .CHNL_RX_CLK(d_unused_rxclk[1]), .CHNL_RX(rx_req && sel == 2'd1), .CHNL_RX_ACK(d_ack[1]),
        .CHNL_RX_LAST(1'b1), .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(31'd0),
        .CHNL_RX_DATA(rx_data[31:0]), .CHNL_RX_DATA_VALID(rx_valid), .CHNL_RX_DATA_REN(d_ren[1]),
        .CHNL_TX_CLK(d_unused_txclk[1]), .CHNL_TX(d_tx[1]), .CHNL_TX_ACK(d_tx[1]),
        .CHNL_TX_LAST(d_last[1]), .CHNL_TX_LEN(d_tx_len[1]), .CHNL_TX_OFF(d_off[1]),
        .CHNL_TX_DATA(data1), .CHNL_TX_DATA_VALID(d_valid[1]), .CHNL_TX_DATA_REN(tx_ren));

    iob_pcie_chnl_loopback #(.C_PCI_DATA_WIDTH(128), .C_FIFO_AW(6)) u_dut2 (
        .CLK(clk), .RST(rst), .MODE(mode), .STATUS(d_status[2]),
        .CHNL_RX_CLK(d_unused_rxclk[2]), .CHNL_RX(rx_req && sel == 2'd2), .CHNL_RX_ACK(d_ack[2]),
        .CHNL_RX_LAST(1'b1), .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(31'd0),
        .CHNL_RX_DATA(rx_data), .CHNL_RX_DATA_VALID(rx_valid), .CHNL_RX_DATA_REN(d_ren[2]),
        .CHNL_TX_CLK(d_unused_txclk[2]), .CHNL_TX(d_tx[2]), .CHNL_TX_ACK(d_tx[2]),
        .CHNL_TX_LAST(d_last[2]), .CHNL_TX_LEN(d_tx_len[2]), .CHNL_TX_OFF(d_off[2]),
        .CHNL_TX_DATA(data2), .CHNL_TX_DATA_VALID(d_valid[2]), .CHNL_TX_DATA_REN(tx_ren));

    always_comb begin
        ack      = d_ack[sel];
        ren      = d_ren[sel];
        tx       = d_tx[sel];
        tx_valid = d_valid[sel];
        tx_last  = d_last[sel];
        status   = d_status[sel];
        tx_len   = d_tx_len[sel];
        tx_off   = d_off[sel];
        tx_data  = (sel == 2'd0) ? {64'd0, data0} : (sel == 2'd1) ? {96'd0, data1} : data2;
    end

    function automatic int wpb_of(input logic [1:0] s);
        return (s == 2'd0) ? 2 : (s == 2'd1) ? 1 : 4;
    endfunction

    // Echo-mode words that fit in the FIFO go onto the scoreboard as they are driven.
    task automatic do_rx(input logic [1:0] m, input int len, input int nbeats,
                         input bit drop_early, input int push_words, input logic [15:0] seed);
        int t;
        int w;
        logic [31:0] word;
        mode = m; rx_len = 32'(len); rx_req = 1'b1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!ack && t < 20);
        checks++;
        if (t !== 1 || ack !== 1'b1) begin
            errors++; $display("FAIL rx_ack_latency: ack=%0b after %0d cycles, required 1 after 1", ack, t);
        end
        w = 0;
        for (int b = 0; b < nbeats; b++) begin
            rx_data = '0;
            for (int l = 0; l < wpb_of(sel); l++) begin
                word = {seed, 16'(w)};
                rx_data[l*32 +: 32] = word;
                if (m == 2'd0 && w < push_words) exp_q.push_back(word);
                w++;
            end
            rx_valid = 1'b1;
            if (b == nbeats - 1 && !drop_early) rx_req = 1'b0;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0; rx_req = 1'b0; rx_data = '0;
    endtask

    task automatic do_tx(input int exp_len, input bit toggle);
        int t, words, cyc;
        bit hold_chk;
        logic [127:0] held;
        logic [31:0] exp;
        t = 0;
        while (!tx && t < 20) begin @(posedge clk); #1; t++; end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL tx_start: CHNL_TX=%0b required 1", tx); end
        checks++;
        if (tx_len !== 32'(exp_len)) begin
            errors++; $display("FAIL tx_len: got %0d required %0d", tx_len, exp_len);
        end
        words = 0; cyc = 0; hold_chk = 1'b0; held = '0;
        while (words < exp_len && cyc < 200) begin
            tx_ren = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (hold_chk && tx_valid) begin
                checks++;
                if (tx_data !== held) begin
                    errors++; $display("FAIL tx_hold: data %h required %h", tx_data, held);
                end
            end
            hold_chk = 1'b0;
            if (tx_valid && tx_ren) begin
                for (int l = 0; l < wpb_of(sel); l++) begin
                    if (words < exp_len) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL tx_scoreboard_empty: word %0d got %h", words, tx_data[l*32 +: 32]);
                        end else begin
                            exp = exp_q.pop_front();
                            if (tx_data[l*32 +: 32] !== exp) begin
                                errors++; $display("FAIL tx_data word %0d: got %h required %h", words, tx_data[l*32 +: 32], exp);
                            end
                        end
                        words++;
                    end
                end
            end else if (tx_valid) begin
                held = tx_data; hold_chk = 1'b1;
            end
            @(posedge clk); #1; cyc++;
        end
        tx_ren = 1'b0;
        checks++;
        if (words < exp_len) begin errors++; $display("FAIL tx_timeout: %0d words required %0d", words, exp_len); end
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL tx_drop: CHNL_TX=%0b required 0", tx); end
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        checks++;
        if (status !== exp) begin errors++; $display("FAIL %s: STATUS=%h required %h", name, status, exp); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s); #1;
            checks++;
            if ({ack, ren, tx, tx_valid} !== 4'b0000) begin
                errors++; $display("FAIL reset_handshake dut%0d: got %b required 0000", s, {ack, ren, tx, tx_valid});
            end
            checks++;
            if (tx_len !== 32'd0 || tx_data !== 128'd0) begin
                errors++; $display("FAIL reset_tx dut%0d: len=%h data=%h required 0", s, tx_len, tx_data);
            end
            check_status("reset_status", 32'd0);
            checks++;
            if (tx_last !== 1'b1 || tx_off !== 31'd0) begin
                errors++; $display("FAIL reset_const dut%0d: last=%0b off=%h required 1/0", s, tx_last, tx_off);
            end
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_echo();
        sel = 2'd0; exp_q.delete();
        do_rx(2'd0, 8, 4, 1'b0, 8, 16'h00E0);
        do_tx(8, 1'b0);
        check_status("echo_status", 32'h0000_0008);
    endtask

    task automatic test_overflow();
        sel = 2'd1; exp_q.delete();
        do_rx(2'd0, 6, 6, 1'b0, 4, 16'h00F0);
        do_tx(4, 1'b0);
        check_status("overflow_status", 32'h4000_0006);
    endtask

    task automatic test_pattern();
        sel = 2'd2; exp_q.delete();
        for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i));
        do_rx(2'd1, 8, 2, 1'b0, 0, 16'h00A0);
        do_tx(8, 1'b0);
        check_status("pattern_status", 32'h0000_0008);
    endtask

    task automatic test_sink_zero();
        int snap;
        sel = 2'd1; exp_q.delete();
        snap = tx_cycles;
        do_rx(2'd2, 16, 16, 1'b0, 0, 16'h00B0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (tx_cycles !== snap) begin errors++; $display("FAIL sink_no_tx: %0d TX cycles required 0", tx_cycles - snap); end
        check_status("sink_status", 32'h0000_0010);
        for (int m = 0; m < 2; m++) begin
            snap = tx_cycles;
            mode = 2'(m); rx_len = 32'd0; rx_req = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL zero_ack mode%0d: ack=%0b required 1", m, ack); end
            rx_req = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            check_status("zero_len_idle", 32'd0);
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (tx_cycles !== snap) begin errors++; $display("FAIL zero_no_tx mode%0d: %0d TX cycles required 0", m, tx_cycles - snap); end
        end
    endtask

    task automatic test_abort_backpressure();
        sel = 2'd1; exp_q.delete();
        do_rx(2'd0, 10, 3, 1'b1, 3, 16'h00C0);
        do_tx(3, 1'b1);
        check_status("abort_status", 32'h2000_0003);
    endtask

    task automatic test_reset_during_tx();
        int t;
        sel = 2'd0; exp_q.delete();
        do_rx(2'd0, 8, 4, 1'b0, 8, 16'h00D0);
        t = 0;
        while (!tx && t < 20) begin @(posedge clk); #1; t++; end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx_start: CHNL_TX=%0b required 1", tx); end
        tx_ren = 1'b1;
        @(posedge clk); #1;
        tx_ren = 1'b0;
        rst = 1'b1; #1;
        checks++;
        if ({tx, tx_valid, ack} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_tx_handshake: got %b required 000", {tx, tx_valid, ack});
        end
        checks++;
        if (tx_len !== 32'd0 || tx_data !== 128'd0) begin
            errors++; $display("FAIL rst_mid_tx_data: len=%h data=%h required 0", tx_len, tx_data);
        end
        check_status("rst_mid_tx_status", 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; exp_q.delete();
        do_rx(2'd0, 4, 2, 1'b0, 4, 16'h00D1);
        do_tx(4, 1'b0);
        check_status("rst_after_status", 32'h0000_0004);
    endtask

    initial begin
        test_reset();
        test_echo();
        test_overflow();
        test_pattern();
        test_sink_zero();
        test_abort_backpressure();
        test_reset_during_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
